// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity and data-length encodings,
// oversampling constants and small decode helpers.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int OVS = 16;
    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_LAST  = 4'd9;

    function automatic logic [3:0] data_len(input logic [1:0] code);
        logic [3:0] len;
        case (code)
            DBITS_5: len = 4'd5;
            DBITS_6: len = 4'd6;
            DBITS_7: len = 4'd7;
            DBITS_8: len = 4'd8;
            default: len = 4'd8;
        endcase
        return len;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_EVEN, PAR_ODD:     en = 1'b1;
            PAR_NONE, PAR_NONE_ALT: en = 1'b0;
            default:               en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock tick every divisor+1 clocks, restartable
// so a receiver can phase-align it to a detected start edge.
module uart_baud_gen #(
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == divisor);

    // >= also recovers cleanly if divisor is lowered below the running count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt >= divisor) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: synchroniser, 16x majority-sampling FSM
// and a valid/ready holding register carrying per-word error status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS_MAX   = 8,
    parameter int DIV_W       = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DBITS_MAX-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int BC_W = $clog2(DBITS_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;
    logic                   tick;

    logic [2:0]             state;
    logic [3:0]             s_cnt;
    logic [BC_W-1:0]        bit_cnt;
    logic [DBITS_MAX-1:0]   shreg;
    logic [1:0]             dbits_q;
    logic [1:0]             pmode_q;
    logic                   stop2_q;
    logic                   smp_a;
    logic                   smp_b;
    logic                   par_acc;
    logic                   all_zero;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   brk_q;

    logic                   decide;
    logic                   maj;
    logic                   last_bit;
    logic                   frame_done;
    logic                   done_ferr;
    logic                   done_brk;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == ST_IDLE) && fall),
        .divisor (divisor),
        .tick    (tick)
    );

    // The third sample is the live synchronised line, so the vote and every
    // state transition land on the same tick at s_cnt 9.
    always_comb begin
        decide     = tick && (state != ST_IDLE) && (s_cnt == SMP_LAST);
        maj        = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
        last_bit   = (bit_cnt == BC_W'(data_len(dbits_q) - 4'd1));
        frame_done = decide && (((state == ST_STOP1) && !stop2_q) || (state == ST_STOP2));
        done_ferr  = ferr_q | ~maj;
        done_brk   = (state == ST_STOP1) ? (all_zero & ~maj) : brk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            dbits_q  <= '0;
            pmode_q  <= '0;
            stop2_q  <= 1'b0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            par_acc  <= 1'b0;
            all_zero <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (fall) begin
                state    <= ST_START;
                s_cnt    <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
                dbits_q  <= data_bits;
                pmode_q  <= parity_mode;
                stop2_q  <= stop_bits;
                par_acc  <= 1'b0;
                all_zero <= 1'b1;
                perr_q   <= 1'b0;
                ferr_q   <= 1'b0;
                brk_q    <= 1'b0;
            end
        end else if (tick) begin
            s_cnt <= (s_cnt == 4'(OVS - 1)) ? 4'd0 : s_cnt + 4'd1;
            if (s_cnt == SMP_FIRST) smp_a <= rx_s;
            if (s_cnt == SMP_MID)   smp_b <= rx_s;
            if (decide) begin
                case (state)
                    ST_START: state <= maj ? ST_IDLE : ST_DATA;
                    ST_DATA: begin
                        shreg[bit_cnt] <= maj;
                        par_acc        <= par_acc ^ maj;
                        all_zero       <= all_zero & ~maj;
                        bit_cnt        <= bit_cnt + BC_W'(1);
                        if (last_bit) begin
                            state <= parity_enabled(pmode_q) ? ST_PARITY : ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        perr_q   <= maj ^ par_acc ^ (pmode_q == PAR_ODD);
                        all_zero <= all_zero & ~maj;
                        state    <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        ferr_q <= done_ferr;
                        brk_q  <= all_zero & ~maj;
                        state  <= stop2_q ? ST_STOP2 : ST_IDLE;
                    end
                    ST_STOP2: begin
                        ferr_q <= done_ferr;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // A completing frame may reuse the slot in the same cycle it is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shreg;
                    parity_err <= perr_q;
                    frame_err  <= done_ferr;
                    break_det  <= done_brk;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frame scenarios plus random
// frames, compared against a line-level model of what each frame should yield.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] divisor;
    logic [1:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        rx;
    logic        rx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        parity_err;
    logic        frame_err;
    logic        break_det;
    logic        overrun;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } word_t;

    word_t cap_q[$];
    int    rd_idx       = 0;
    int    ovr_cnt      = 0;
    int    valid_cycles = 0;
    logic  prev_valid   = 1'b0;
    int    checks       = 0;
    int    failures     = 0;
    int    bit_clks     = 64;
    word_t exp_w;

    uart_rx_cfg #(.DBITS_MAX(8), .DIV_W(11), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .divisor     (divisor),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Record each newly presented word, overrun pulses and valid-high cycles.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (rx_valid && !prev_valid) cap_q.push_back({rx_data, parity_err, frame_err, break_det});
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (rx_valid) valid_cycles <= valid_cycles + 1;
            prev_valid <= rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int div, input logic [1:0] dbits, input logic [1:0] pmode, input logic two);
        divisor     = 11'(div);
        data_bits   = dbits;
        parity_mode = pmode;
        stop_bits   = two;
        bit_clks    = 16 * (div + 1);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    // par_force < 0 sends the correct parity bit; 0/1 forces that value.
    task automatic apply_stimulus(input logic [7:0] data, input int par_force, input logic s1, input logic s2);
        int         n;
        logic [7:0] d;
        logic [8:0] mask;
        logic       par_en;
        logic       natural_p;
        logic       pbit;
        logic [1:0] dbits_sv;
        logic [1:0] pmode_sv;
        logic       two_sv;
        dbits_sv  = data_bits;
        pmode_sv  = parity_mode;
        two_sv    = stop_bits;
        n         = int'(dbits_sv) + 5;
        mask      = (9'd1 << n) - 9'd1;
        d         = data & mask[7:0];
        par_en    = (pmode_sv == 2'b01) || (pmode_sv == 2'b10);
        natural_p = (^d) ^ (pmode_sv == 2'b10);
        pbit      = (par_force < 0) ? natural_p : par_force[0];
        exp_w.data = d;
        exp_w.pe   = par_en && (pbit != natural_p);
        exp_w.fe   = !s1 || (two_sv && !s2);
        exp_w.brk  = (d == 8'h00) && (!par_en || !pbit) && !s1;

        drive_bit(1'b0);
        data_bits   = 2'($urandom);
        parity_mode = 2'($urandom);
        stop_bits   = 1'($urandom);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(s1);
        if (two_sv) drive_bit(s2);
        rx = 1'b1;
        repeat (2 * bit_clks) @(negedge clk);
        data_bits   = dbits_sv;
        parity_mode = pmode_sv;
        stop_bits   = two_sv;
    endtask

    task automatic check_output(input string tag);
        word_t obs;
        obs = 'x;
        check({tag, "_count"}, cap_q.size(), rd_idx + 1);
        if (cap_q.size() > rd_idx) obs = cap_q[rd_idx];
        rd_idx = cap_q.size();
        check({tag, "_data"}, obs.data, exp_w.data);
        check({tag, "_perr"}, obs.pe, exp_w.pe);
        check({tag, "_ferr"}, obs.fe, exp_w.fe);
        check({tag, "_brk"},  obs.brk, exp_w.brk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   rx_valid,   1'b0);
        check({tag, "_data"},    rx_data,    8'h00);
        check({tag, "_perr"},    parity_err, 1'b0);
        check({tag, "_ferr"},    frame_err,  1'b0);
        check({tag, "_brk"},     break_det,  1'b0);
        check({tag, "_overrun"}, overrun,    1'b0);
    endtask

    initial begin
        int v0;
        int o0;
        logic [7:0] b32;
        rx       = 1'b1;
        rx_ready = 1'b1;
        reset    = 1'b1;
        set_cfg(3, 2'b11, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] 8N1 0xA5");
        v0 = valid_cycles;
        apply_stimulus(8'hA5, -1, 1'b1, 1'b1);
        check_output("8n1_a5");
        check("8n1_valid_cycles", valid_cycles - v0, 1);

        $display("[TB] 7E1 parity");
        set_cfg(3, 2'b10, 2'b01, 1'b0);
        apply_stimulus(8'h3C, -1, 1'b1, 1'b1);
        check_output("7e1_good");
        apply_stimulus(8'h3C, 1, 1'b1, 1'b1);
        check_output("7e1_bad");

        $display("[TB] 5O2");
        set_cfg(3, 2'b00, 2'b10, 1'b1);
        apply_stimulus(8'h15, -1, 1'b1, 1'b1);
        check_output("5o2_good");
        apply_stimulus(8'h15, -1, 1'b1, 1'b0);
        check_output("5o2_stop2");

        $display("[TB] false start and break");
        set_cfg(3, 2'b11, 2'b00, 1'b0);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * bit_clks) @(negedge clk);
        check("false_start_none", cap_q.size(), rd_idx);
        apply_stimulus(8'h00, -1, 1'b0, 1'b1);
        check_output("break");

        $display("[TB] overrun");
        rx_ready = 1'b0;
        apply_stimulus(8'h11, -1, 1'b1, 1'b1);
        check_output("ovr_first");
        o0 = ovr_cnt;
        apply_stimulus(8'h22, -1, 1'b1, 1'b1);
        check("ovr_pulse_cycles", ovr_cnt - o0, 1);
        check("ovr_held_data", rx_data, 8'h11);
        check("ovr_held_valid", rx_valid, 1'b1);
        check("ovr_no_new_word", cap_q.size(), rd_idx);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ready_clears_valid", rx_valid, 1'b0);

        $display("[TB] reset mid-frame");
        b32 = 8'h32;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b32[i]);
        rx = b32[3];
        repeat (bit_clks / 2) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (2 * bit_clks) @(negedge clk);
        check("midreset_no_word", cap_q.size(), rd_idx);
        apply_stimulus(8'h78, -1, 1'b1, 1'b1);
        check_output("after_reset");

        $display("[TB] random frames");
        for (int k = 0; k < 8; k++) begin
            int pf;
            set_cfg(int'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 1'($urandom));
            pf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            apply_stimulus(8'($urandom), pf, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
            check_output($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
